dac_serializer: RTL and testbench

Output stage of the equalizer path. Takes the 23-bit two's-complement sample chosen by the band/output multiplexer (bass, mid, treble or full signal), reduces it to the DAC resolution, converts it to offset binary and shifts it MSB-first into a serial SPI-style audio DAC. Sits directly downstream of the output mux and is the last block before the board pins.

---
 rtl/dac_serializer.sv | 135 +++++++++++++
 tb/tb_dac_serializer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/dac_serializer.sv
// Serializes one sample as {cmd, offset-binary code} MSB-first to an SPI-style audio DAC.
// Define DAC_ROUND_EN to round the code to nearest (with saturation) instead of truncating.
`timescale 1ns/1ps
module dac_serializer #(
    parameter int         ancho    = 23,
    parameter int         bits_dac = 12,
    parameter logic [3:0] cmd      = 4'b0011,
    parameter int         div      = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ancho-1:0] muestra,
    input  logic             start,
    output logic             sclk,
    output logic             mosi,
    output logic             cs_n,
    output logic             busy,
    output logic             done
);
    localparam int FRAME = 4 + bits_dac;
    localparam int BW    = $clog2(FRAME);
    localparam int DW    = (div > 1) ? $clog2(div) : 1;
    localparam logic [BW-1:0] BIT_TOP = BW'(FRAME - 1);
    localparam logic [DW-1:0] DIV_TOP = DW'(div - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

    state_t            state, state_d;
    logic [FRAME-1:0]  sh, sh_d;
    logic [BW-1:0]     bitcnt, bitcnt_d;
    logic [DW-1:0]     divcnt, divcnt_d;
    logic              sclk_d, mosi_d, cs_n_d, busy_d, done_d;
    logic [bits_dac-1:0] codigo;

`ifdef DAC_ROUND_EN
    localparam logic [ancho:0] RND = {{(bits_dac + 1){1'b0}}, 1'b1, {(ancho - bits_dac - 1){1'b0}}};
    logic [ancho:0] suma;
    logic           unused_bits;

    // Sign-extended add: a carry into the top bit that disagrees with the sign marks positive overflow.
    always_comb begin
        suma = {muestra[ancho-1], muestra} + RND;
        if (suma[ancho] != suma[ancho-1])
            codigo = '1;
        else
            codigo = {~suma[ancho-1], suma[ancho-2 -: bits_dac-1]};
    end
    assign unused_bits = ^suma[ancho-bits_dac-1:0];
`else
    logic unused_bits;
    assign codigo      = {~muestra[ancho-1], muestra[ancho-2 -: bits_dac-1]};
    assign unused_bits = ^muestra[ancho-bits_dac-1:0];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            sh     <= '0;
            bitcnt <= '0;
            divcnt <= '0;
            sclk   <= 1'b0;
            mosi   <= 1'b0;
            cs_n   <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_d;
            sh     <= sh_d;
            bitcnt <= bitcnt_d;
            divcnt <= divcnt_d;
            sclk   <= sclk_d;
            mosi   <= mosi_d;
            cs_n   <= cs_n_d;
            busy   <= busy_d;
            done   <= done_d;
        end
    end

    always_comb begin
        state_d  = state;
        sh_d     = sh;
        bitcnt_d = bitcnt;
        divcnt_d = divcnt;
        sclk_d   = sclk;
        mosi_d   = mosi;
        cs_n_d   = cs_n;
        busy_d   = busy;
        done_d   = 1'b0;
        case (state)
            IDLE: begin
                sclk_d = 1'b0;
                mosi_d = 1'b0;
                cs_n_d = 1'b1;
                busy_d = 1'b0;
                if (start) begin
                    sh_d     = {cmd, codigo};
                    mosi_d   = cmd[3];
                    cs_n_d   = 1'b0;
                    busy_d   = 1'b1;
                    bitcnt_d = BIT_TOP;
                    divcnt_d = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (divcnt != DIV_TOP) begin
                    divcnt_d = divcnt + DW'(1);
                end else begin
                    divcnt_d = '0;
                    if (!sclk) begin
                        sclk_d = 1'b1;
                    end else if (bitcnt == '0) begin
                        // Last high phase ends: leave sclk low and close the frame without another edge.
                        state_d = FIN;
                        sclk_d  = 1'b0;
                        mosi_d  = 1'b0;
                        cs_n_d  = 1'b1;
                        done_d  = 1'b1;
                        sh_d    = '0;
                    end else begin
                        sclk_d   = 1'b0;
                        bitcnt_d = bitcnt - BW'(1);
                        sh_d     = {sh[FRAME-2:0], 1'b0};
                        mosi_d   = sh[FRAME-2];
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dac_serializer.sv
// Bench for dac_serializer: a div=2 and a div=1 instance, frames decoded on sclk rises and scoreboarded.
`timescale 1ns/1ps
module tb_dac_serializer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [22:0] muestra [2];
    logic        start [2];
    logic        sclk [2];
    logic        mosi [2];
    logic        cs_n [2];
    logic        busy [2];
    logic        done [2];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    dac_serializer #(.ancho(23), .bits_dac(12), .cmd(4'b0011), .div(2)) dut_a (
        .clk(clk), .reset(reset), .muestra(muestra[0]), .start(start[0]),
        .sclk(sclk[0]), .mosi(mosi[0]), .cs_n(cs_n[0]), .busy(busy[0]), .done(done[0])
    );

    dac_serializer #(.ancho(23), .bits_dac(12), .cmd(4'b0011), .div(1)) dut_b (
        .clk(clk), .reset(reset), .muestra(muestra[1]), .start(start[1]),
        .sclk(sclk[1]), .mosi(mosi[1]), .cs_n(cs_n[1]), .busy(busy[1]), .done(done[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [22:0] m);
        int s;
        int c;
        s = int'({{9{m[22]}}, m});
`ifdef DAC_ROUND_EN
        s = s + 1024;
`endif
        c = s >>> 11;
        if (c > 2047) c = 2047;
        return {4'b0011, 12'(c + 2048)};
    endfunction

    for (genvar k = 0; k < 2; k++) begin : mon
        localparam int DV = (k == 0) ? 2 : 1;
        logic [15:0] expq [$];
        logic [15:0] acc = '0;
        logic [15:0] want;
        int          nbits = 0;
        int          bcnt = 0;
        int          stab = 0;
        logic        psclk = 1'b0;
        logic        pmosi = 1'b0;

        always @(negedge clk) begin
            if (mosi[k] !== pmosi) stab = 0;
            else stab++;
            if (reset) begin
                acc   = '0;
                nbits = 0;
            end else if (sclk[k] && !psclk && !cs_n[k]) begin
                acc = {acc[14:0], mosi[k]};
                nbits++;
                chk($sformatf("setup%0d", k), 32'(stab >= DV), 32'd1);
            end
            bcnt = busy[k] ? bcnt + 1 : 0;
            if (done[k]) begin
                chk($sformatf("done_expected%0d", k), 32'(expq.size() > 0), 32'd1);
                if (expq.size() > 0) begin
                    want = expq.pop_front();
                    chk($sformatf("frame%0d", k), 32'(acc), 32'(want));
                end
                chk($sformatf("rises%0d", k), nbits, 32'd16);
                chk($sformatf("busy_len%0d", k), bcnt, 32'(2 * 16 * DV + 1));
                chk($sformatf("fin_cs_n%0d", k), 32'(cs_n[k]), 32'd1);
                chk($sformatf("fin_mosi%0d", k), 32'(mosi[k]), 32'd0);
                chk($sformatf("fin_sclk%0d", k), 32'(sclk[k]), 32'd0);
                acc   = '0;
                nbits = 0;
            end
            psclk = sclk[k];
            pmosi = mosi[k];
        end
    end

    task automatic push(input int k, input logic [22:0] m);
        if (k == 0) mon[0].expq.push_back(model(m));
        else        mon[1].expq.push_back(model(m));
    endtask

    task automatic send(input int k, input logic [22:0] m);
        @(posedge clk); #1;
        muestra[k] = m;
        start[k]   = 1'b1;
        push(k, m);
        @(posedge clk); #1;
        start[k] = 1'b0;
        chk("start_cs_n", 32'(cs_n[k]), 32'd0);
        chk("start_busy", 32'(busy[k]), 32'd1);
        chk("start_sclk", 32'(sclk[k]), 32'd0);
    endtask

    task automatic wait_done(input int k);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (done[k]) seen = 1'b1;
        end
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        muestra[0] = '0; muestra[1] = '0;
        start[0] = 1'b0; start[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_cs_n", 32'(cs_n[k]), 32'd1);
            chk("rst_sclk", 32'(sclk[k]), 32'd0);
            chk("rst_mosi", 32'(mosi[k]), 32'd0);
            chk("rst_busy", 32'(busy[k]), 32'd0);
            chk("rst_done", 32'(done[k]), 32'd0);
        end
        reset = 1'b0;

        send(0, 23'h000000); wait_done(0);
        send(0, 23'h400000); wait_done(0);
        send(0, 23'h3FFFFF); wait_done(0);
        send(0, 23'h000400); wait_done(0);
        send(0, 23'h0003FF); wait_done(0);
        send(0, 23'h123456); wait_done(0);

        // Starts mid-frame must be ignored and must not disturb the captured sample.
        send(0, 23'h0ABCDE);
        repeat (8) @(posedge clk);
        #1; muestra[0] = 23'h7FFFFF; start[0] = 1'b1;
        @(posedge clk); #1; start[0] = 1'b0;
        repeat (19) @(posedge clk);
        #1; muestra[0] = 23'h2AAAAA; start[0] = 1'b1;
        @(posedge clk); #1; start[0] = 1'b0; muestra[0] = 23'h555555;
        wait_done(0);

        // Back-to-back: start held through FIN is taken in the single idle cycle.
        send(0, 23'h155555); wait_done(0);
        muestra[0] = 23'h600000;
        start[0]   = 1'b1;
        push(0, 23'h600000);
        @(posedge clk); #1;
        chk("gap_busy", 32'(busy[0]), 32'd0);
        chk("gap_cs_n", 32'(cs_n[0]), 32'd1);
        @(posedge clk); #1;
        start[0] = 1'b0;
        chk("b2b_busy", 32'(busy[0]), 32'd1);
        chk("b2b_cs_n", 32'(cs_n[0]), 32'd0);
        wait_done(0);

        // Abort at bit 7, then a clean frame.
        send(0, 23'h2468AC);
        repeat (33) @(posedge clk);
        #1; reset = 1'b1;
        void'(mon[0].expq.pop_front());
        @(posedge clk); #1;
        chk("abort_cs_n", 32'(cs_n[0]), 32'd1);
        chk("abort_sclk", 32'(sclk[0]), 32'd0);
        chk("abort_busy", 32'(busy[0]), 32'd0);
        chk("abort_done", 32'(done[0]), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("abort_done2", 32'(done[0]), 32'd0);
        send(0, 23'h2468AC); wait_done(0);

        send(1, 23'h000000); wait_done(1);
        send(1, 23'h3FFFFF); wait_done(1);
        send(1, 23'h123456); wait_done(1);

        repeat (4) @(posedge clk);
        chk("queue_empty0", 32'(mon[0].expq.size()), 32'd0);
        chk("queue_empty1", 32'(mon[1].expq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
